onc_16_dmem: RTL and testbench

ONC_16_DMEM -- requirements
Module: onc_16_dmem

---
 rtl/onc_16_dmem_pkg.sv | 80 ++++++++
 rtl/onc_16_dmem_ram.sv | 38 +++
 rtl/onc_16_dmem.sv | 168 ++++++++++++++++
 tb/tb_onc_16_dmem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onc_16_dmem_pkg.sv
// ---------------------------------------------------------------------------
// onc_16_dmem_pkg
//
// Shared definitions for the ONC-16 data-memory block.
//
// The `define block below plays the role of the project-wide def.v: it holds
// the data width, the "undefined read" pattern and the memory-mapped register
// addresses. The package mirrors those macros as typed localparams and adds
// the decoded-select enum, the timer state struct and the address decoder so
// the top level only has to deal with one-hot-ish selects.
//
// No ports (package).
// ---------------------------------------------------------------------------
`ifndef ONC_16_DMEM_DEF
`define ONC_16_DMEM_DEF
`define DATA_W        16
`define DATA_UD       16'hDEAD
`define IO_OUT_ADDR   16'hFF00
`define IO_IN_ADDR    16'hFF01
`define TMR_RELOAD_ADDR 16'hFF02
`define TMR_COUNT_ADDR  16'hFF03
`define TMR_CTRL_ADDR   16'hFF04
`endif

package onc_16_dmem_pkg;

   localparam int DATA_W = `DATA_W;

   localparam logic [DATA_W-1:0] DATA_UD         = `DATA_UD;
   localparam logic [DATA_W-1:0] IO_OUT_ADDR     = `IO_OUT_ADDR;
   localparam logic [DATA_W-1:0] IO_IN_ADDR      = `IO_IN_ADDR;
   localparam logic [DATA_W-1:0] TMR_RELOAD_ADDR = `TMR_RELOAD_ADDR;
   localparam logic [DATA_W-1:0] TMR_COUNT_ADDR  = `TMR_COUNT_ADDR;
   localparam logic [DATA_W-1:0] TMR_CTRL_ADDR   = `TMR_CTRL_ADDR;

   // Bit positions inside TMR_CTRL.
   localparam int CTRL_RUN_BIT = 0;
   localparam int CTRL_IRQ_BIT = 1;

   // Result of decoding one CPU address.
   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_IO_OUT,
      SEL_IO_IN,
      SEL_TMR_RELOAD,
      SEL_TMR_COUNT,
      SEL_TMR_CTRL
   } sel_e;

   // Complete architectural state of the interval timer.
   typedef struct packed {
      logic [DATA_W-1:0] reload;
      logic [DATA_W-1:0] count;
      logic              run;
      logic              irq;
   } tmr_t;

   // RAM occupies the bottom 2**ram_aw words; every address with a non-zero
   // bit at or above ram_aw falls through to the register map.
   function automatic sel_e dmem_decode(input logic [DATA_W-1:0] addr,
                                        input int                ram_aw);
      sel_e sel;
      sel = SEL_NONE;
      if ((addr >> ram_aw) == '0) begin
         sel = SEL_RAM;
      end else begin
         case (addr)
            IO_OUT_ADDR:     sel = SEL_IO_OUT;
            IO_IN_ADDR:      sel = SEL_IO_IN;
            TMR_RELOAD_ADDR: sel = SEL_TMR_RELOAD;
            TMR_COUNT_ADDR:  sel = SEL_TMR_COUNT;
            TMR_CTRL_ADDR:   sel = SEL_TMR_CTRL;
            default:         sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/onc_16_dmem_ram.sv
// ---------------------------------------------------------------------------
// onc_16_dmem_ram
//
// Word-wide data RAM: asynchronous (combinational) read, synchronous write,
// no reset. Contents survive a system reset by design.
//
// Ports:
//   clock  in   system clock, write on rising edge
//   we     in   write strobe (already qualified by enable/reset/decode)
//   addr   in   RAM_AW-bit word address, shared by read and write
//   wdata  in   write data
//   rdata  out  read data for addr, same cycle
// ---------------------------------------------------------------------------
module onc_16_dmem_ram
   import onc_16_dmem_pkg::*;
#(
   parameter int RAM_AW = 10
) (
   input  logic              clock,
   input  logic              we,
   input  logic [RAM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << RAM_AW;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/onc_16_dmem.sv
// ---------------------------------------------------------------------------
// onc_16_dmem
//
// Data-memory subsystem for the ONC-16 CPU: RAM, a registered output port,
// a synchronized input port and a reloadable down-counting interval timer,
// all behind one combinational-read / synchronous-write CPU port.
//
// Address map:
//   0x0000 .. 2**RAM_AW-1  RAM
//   0xFF00 IO_OUT      R/W
//   0xFF01 IO_IN       R   (second synchronizer flop)
//   0xFF02 TMR_RELOAD  R/W (a write also loads TMR_COUNT)
//   0xFF03 TMR_COUNT   R
//   0xFF04 TMR_CTRL    R/W bit0 run, bit1 irq flag (write 1 clears)
//   anything else reads `DATA_UD, writes ignored
//
// Ports:
//   clock      in   system clock, rising edge
//   n_rst      in   synchronous active-low reset (wins over en)
//   en         in   global enable; low freezes every flop including RAM
//   dmem_addr  in   CPU word address
//   dmem_dout  in   CPU write data
//   dmem_we    in   CPU write strobe
//   dmem_din   out  CPU read data, combinational from dmem_addr
//   io_in      in   asynchronous external input
//   io_out     out  IO_OUT register
//   tmr_irq    out  sticky timer-expiry flag
// ---------------------------------------------------------------------------
module onc_16_dmem
   import onc_16_dmem_pkg::*;
#(
   parameter int RAM_AW = 10
) (
   input  logic              clock,
   input  logic              n_rst,
   input  logic              en,
   input  logic [DATA_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_dout,
   input  logic              dmem_we,
   output logic [DATA_W-1:0] dmem_din,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] io_out,
   output logic              tmr_irq
);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   sel_e sel;
   logic wr_en;

   assign sel   = dmem_decode(dmem_addr, RAM_AW);
   assign wr_en = en & dmem_we;

   // ------------------------------------------------------------------
   // RAM. The write is also gated by n_rst so a write that coincides with
   // reset is dropped, matching the register side.
   // ------------------------------------------------------------------
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   assign ram_we = n_rst & wr_en & (sel == SEL_RAM);

   onc_16_dmem_ram #(
      .RAM_AW (RAM_AW)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (dmem_addr[RAM_AW-1:0]),
      .wdata (dmem_dout),
      .rdata (ram_rdata)
   );

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] io_out_q, io_out_d;
   logic [DATA_W-1:0] sync1_q,  sync1_d;
   logic [DATA_W-1:0] sync2_q,  sync2_d;
   tmr_t              tmr_q,    tmr_d;
   logic              tmr_expire;

   always_comb begin
      io_out_d   = io_out_q;
      sync1_d    = sync1_q;
      sync2_d    = sync2_q;
      tmr_d      = tmr_q;
      tmr_expire = 1'b0;

      if (en) begin
         sync1_d = io_in;
         sync2_d = sync1_q;

         // Expiry is judged on the count held during this cycle; reaching
         // zero takes one edge and reloading takes the next, so a reload
         // value of N gives a period of N+1 cycles.
         tmr_expire = tmr_q.run && (tmr_q.count == '0);
         if (tmr_q.run) begin
            if (tmr_expire) begin
               tmr_d.count = tmr_q.reload;
            end else begin
               tmr_d.count = tmr_q.count - DATA_W'(1);
            end
         end

         // CPU writes come after the timer update so a RELOAD write
         // overrides whatever the counter was about to do.
         if (dmem_we) begin
            case (sel)
               SEL_IO_OUT: begin
                  io_out_d = dmem_dout;
               end
               SEL_TMR_RELOAD: begin
                  tmr_d.reload = dmem_dout;
                  tmr_d.count  = dmem_dout;
               end
               SEL_TMR_CTRL: begin
                  tmr_d.run = dmem_dout[CTRL_RUN_BIT];
                  if (dmem_dout[CTRL_IRQ_BIT]) begin
                     tmr_d.irq = 1'b0;
                  end
               end
               default: ;
            endcase
         end

         // Applied last: an expiry on the same edge as a clear keeps the
         // flag set so no event is lost.
         if (tmr_expire) begin
            tmr_d.irq = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!n_rst) begin
         io_out_q <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         tmr_q    <= '0;
      end else begin
         io_out_q <= io_out_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         tmr_q    <= tmr_d;
      end
   end

   // ------------------------------------------------------------------
   // Read mux (zero latency)
   // ------------------------------------------------------------------
   always_comb begin
      dmem_din = DATA_UD;
      case (sel)
         SEL_RAM:        dmem_din = ram_rdata;
         SEL_IO_OUT:     dmem_din = io_out_q;
         SEL_IO_IN:      dmem_din = sync2_q;
         SEL_TMR_RELOAD: dmem_din = tmr_q.reload;
         SEL_TMR_COUNT:  dmem_din = tmr_q.count;
         SEL_TMR_CTRL:   dmem_din = {{(DATA_W-2){1'b0}}, tmr_q.irq, tmr_q.run};
         default:        dmem_din = DATA_UD;
      endcase
   end

   assign io_out  = io_out_q;
   assign tmr_irq = tmr_q.irq;

endmodule

// File: tb/tb_onc_16_dmem.sv
// ---------------------------------------------------------------------------
// tb_onc_16_dmem
//
// Directed scenarios followed by a randomized run, every cycle compared
// against a plain behavioural model of the memory map, IO and timer.
// ---------------------------------------------------------------------------
module tb_onc_16_dmem;

   localparam int          AW    = 10;
   localparam int          DEPTH = 1 << AW;
   localparam logic [15:0] UD    = 16'hDEAD;

   logic        clock = 1'b0;
   logic        n_rst = 1'b0;
   logic        en = 1'b0;
   logic [15:0] dmem_addr = '0;
   logic [15:0] dmem_dout = '0;
   logic        dmem_we = 1'b0;
   logic [15:0] dmem_din;
   logic [15:0] io_in = '0;
   logic [15:0] io_out;
   logic        tmr_irq;

   always #5 clock = ~clock;

   onc_16_dmem #(.RAM_AW(AW)) dut (
      .clock     (clock),
      .n_rst     (n_rst),
      .en        (en),
      .dmem_addr (dmem_addr),
      .dmem_dout (dmem_dout),
      .dmem_we   (dmem_we),
      .dmem_din  (dmem_din),
      .io_in     (io_in),
      .io_out    (io_out),
      .tmr_irq   (tmr_irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   logic [15:0] m_ram [DEPTH];
   bit          m_wr  [DEPTH];
   logic [15:0] m_io_out, m_s1, m_s2, m_reload, m_count;
   logic        m_run, m_irq;
   bit          m_known = 0;

   function automatic logic [15:0] m_read(input logic [15:0] a);
      if (a < DEPTH) return m_ram[a];
      case (a)
         16'hFF00: return m_io_out;
         16'hFF01: return m_s2;
         16'hFF02: return m_reload;
         16'hFF03: return m_count;
         16'hFF04: return {14'd0, m_irq, m_run};
         default:  return UD;
      endcase
   endfunction

   function automatic bit m_defined(input logic [15:0] a);
      return (a >= DEPTH) || m_wr[a];
   endfunction

   task automatic m_edge(input logic rn, input logic e, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] pin);
      logic [15:0] nc;
      logic        ni, nr;
      bit          fire;
      if (!rn) begin
         m_io_out = 0; m_s1 = 0; m_s2 = 0;
         m_reload = 0; m_count = 0; m_run = 0; m_irq = 0;
         m_known  = 1;
      end else if (e) begin
         fire = m_run && (m_count == 0);
         nc   = m_count;
         ni   = m_irq;
         nr   = m_run;
         if (m_run) nc = fire ? m_reload : m_count - 16'd1;
         if (w) begin
            if (a < DEPTH) begin
               m_ram[a] = d;
               m_wr[a]  = 1;
            end
            if (a == 16'hFF00) m_io_out = d;
            if (a == 16'hFF02) begin
               m_reload = d;
               nc       = d;
            end
            if (a == 16'hFF04) begin
               nr = d[0];
               if (d[1]) ni = 0;
            end
         end
         if (fire) ni = 1;
         m_count = nc;
         m_irq   = ni;
         m_run   = nr;
         m_s2    = m_s1;
         m_s1    = pin;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, compare combinational/registered outputs against
   // the model, then advance both across the rising edge.
   task automatic cyc(input logic rn, input logic e, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
      n_rst = rn; en = e; dmem_we = w; dmem_addr = a; dmem_dout = d;
      #1;
      if (m_known) begin
         if (m_defined(a)) chk($sformatf("din@%h", a), dmem_din, m_read(a));
         chk("io_out", io_out, m_io_out);
         chk("tmr_irq", {15'd0, tmr_irq}, {15'd0, m_irq});
      end
      @(posedge clock);
      m_edge(rn, e, w, a, d, io_in);
      #1;
   endtask

   // Look at an address without an edge; expectation given explicitly.
   task automatic peek(input string tag, input logic [15:0] a, input logic [15:0] exp);
      dmem_we = 0; dmem_addr = a;
      #1;
      chk(tag, dmem_din, exp);
   endtask

   logic [15:0] saved_count;

   initial begin
      // reset
      cyc(0, 1, 0, 16'h0000, 16'h0000);
      cyc(0, 0, 0, 16'h0000, 16'h0000);
      chk("rst_io_out", io_out, 16'h0000);
      chk("rst_irq", {15'd0, tmr_irq}, 16'h0000);
      peek("rst_reload", 16'hFF02, 16'h0000);
      peek("rst_count", 16'hFF03, 16'h0000);
      peek("rst_ctrl", 16'hFF04, 16'h0000);
      peek("rst_io_in", 16'hFF01, 16'h0000);

      // RAM write/read and unmapped reads
      cyc(1, 1, 1, 16'h0005, 16'h1234);
      peek("ram5", 16'h0005, 16'h1234);
      peek("unmapped_400", 16'h0400, UD);
      peek("unmapped_ff05", 16'hFF05, UD);
      cyc(1, 1, 1, 16'hFF01, 16'h7777);   // IO_IN is read-only
      cyc(1, 1, 1, 16'hFF03, 16'h7777);   // TMR_COUNT is read-only
      peek("io_in_ro", 16'hFF01, 16'h0000);
      peek("count_ro", 16'hFF03, 16'h0000);

      // IO_OUT and reset persistence of RAM
      cyc(1, 1, 1, 16'hFF00, 16'hA5A5);
      chk("io_out_wr", io_out, 16'hA5A5);
      peek("io_out_rd", 16'hFF00, 16'hA5A5);
      cyc(1, 1, 1, 16'h0006, 16'h1111);
      cyc(0, 1, 1, 16'h0006, 16'hBEEF);   // write under reset is dropped
      chk("io_out_rst", io_out, 16'h0000);
      peek("ram5_keep", 16'h0005, 16'h1234);
      peek("ram6_drop", 16'h0006, 16'h1111);

      // input synchronizer latency
      io_in = 16'h0000;
      cyc(1, 1, 0, 16'hFF01, 0);
      cyc(1, 1, 0, 16'hFF01, 0);
      io_in = 16'h00FF;
      cyc(1, 1, 0, 16'hFF01, 0);
      peek("sync_1edge", 16'hFF01, 16'h0000);
      cyc(1, 1, 0, 16'hFF01, 0);
      peek("sync_2edge", 16'hFF01, 16'h00FF);

      // timer sequence 3,2,1,0,3 with irq on the fourth edge
      cyc(1, 1, 1, 16'hFF02, 16'd3);
      peek("tmr_load", 16'hFF03, 16'd3);
      cyc(1, 1, 1, 16'hFF04, 16'd1);
      peek("tmr_e0", 16'hFF03, 16'd3);
      for (int k = 1; k <= 4; k++) begin
         cyc(1, 1, 0, 16'hFF03, 0);
         peek($sformatf("tmr_e%0d", k), 16'hFF03, (k == 4) ? 16'd3 : 16'(3 - k));
         chk($sformatf("irq_e%0d", k), {15'd0, tmr_irq}, (k == 4) ? 16'd1 : 16'd0);
      end
      peek("ctrl_rd", 16'hFF04, 16'h0003);
      cyc(1, 1, 1, 16'hFF04, 16'd2);
      chk("irq_clear", {15'd0, tmr_irq}, 16'd0);

      // clear on the expiry edge: set wins
      cyc(1, 1, 1, 16'hFF02, 16'd1);
      cyc(1, 1, 1, 16'hFF04, 16'd1);
      cyc(1, 1, 0, 16'hFF03, 0);
      peek("pre_expire", 16'hFF03, 16'd0);
      cyc(1, 1, 1, 16'hFF04, 16'd3);
      chk("set_wins", {15'd0, tmr_irq}, 16'd1);

      // enable low freezes everything
      peek("pre_hold", 16'hFF03, m_count);
      saved_count = m_count;
      cyc(1, 0, 1, 16'h0005, 16'h5555);
      cyc(1, 0, 1, 16'hFF00, 16'h5555);
      cyc(1, 0, 1, 16'hFF02, 16'h0009);
      peek("hold_ram", 16'h0005, 16'h1234);
      peek("hold_count", 16'hFF03, saved_count);
      peek("hold_reload", 16'hFF02, 16'd1);
      chk("hold_io_out", io_out, 16'h0000);

      // reload 0 with run: flag every cycle, count pinned at 0
      cyc(1, 1, 1, 16'hFF02, 16'd0);
      cyc(1, 1, 1, 16'hFF04, 16'd3);
      for (int k = 0; k < 3; k++) begin
         cyc(1, 1, 1, 16'hFF04, 16'd3);
         peek("zero_count", 16'hFF03, 16'd0);
         chk("zero_irq", {15'd0, tmr_irq}, 16'd1);
      end

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] a, d;
         logic        w, e, rn;
         int          r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: a = 16'($urandom_range(0, 15));
            3:       a = 16'($urandom_range(0, DEPTH - 1));
            4:       a = 16'hFF00 + 16'($urandom_range(0, 5));
            5, 6:    a = 16'hFF02 + 16'($urandom_range(0, 2));
            7:       a = 16'h0400 + 16'($urandom_range(0, 16'hF000));
            default: a = 16'hFF03;
         endcase
         if (a == 16'hFF02)      d = 16'($urandom_range(0, 5));
         else if (a == 16'hFF04) d = 16'($urandom_range(0, 3));
         else                    d = 16'($urandom);
         w  = ($urandom_range(0, 2) != 0);
         e  = ($urandom_range(0, 7) != 0);
         rn = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 3) == 0) io_in = 16'($urandom);
         cyc(rn, e, w, a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
